// File: rtl/buf_id_sched_if.sv
// Allocation/release bus between the per-port ingress/egress controllers and buf_id_sched.
interface buf_id_sched_if #(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 8
);
  logic [NUM_PORTS-1:0]      in_alloc_req;
  logic [NUM_PORTS-1:0]      out_alloc_gnt;
  logic [ID_W-1:0]           out_alloc_id;
  logic [NUM_PORTS*ID_W-1:0] in_rel_id;
  logic [NUM_PORTS-1:0]      in_rel_wr;
  logic [NUM_PORTS-1:0]      out_rel_ready;
  logic [5:0]                out_free_count;
  logic                      out_init_done;
  logic                      out_rel_err;

  modport master (
    output in_alloc_req, in_rel_id, in_rel_wr,
    input  out_alloc_gnt, out_alloc_id, out_rel_ready,
           out_free_count, out_init_done, out_rel_err
  );

  modport slave (
    input  in_alloc_req, in_rel_id, in_rel_wr,
    output out_alloc_gnt, out_alloc_id, out_rel_ready,
           out_free_count, out_init_done, out_rel_err
  );
endinterface

// File: rtl/buf_id_sched.sv
// Buffer-ID scheduler: circular free list of 32 IDs, round-robin grant, merged
// per-port release holding registers with in-use bitmap checking.
//
// state  | meaning
// INIT_S | writing IDs 0..31 into free-list entries 0..31, one per cycle; no grants, releases blocked
// RUN_S  | one round-robin grant and one merged release per cycle
module buf_id_sched #(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 8
) (
  input logic           clk,
  input logic           rst_n,
  buf_id_sched_if.slave bus
);
  localparam int ID_NUM = 32;
  localparam int PTR_W  = 5;
  localparam int CNT_W  = 6;
  localparam int PW     = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {INIT_S, RUN_S} state_t;

  state_t state_q, state_n;

  logic [PTR_W-1:0] fl_mem [ID_NUM];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_n;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0] init_cnt_q, init_cnt_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [ID_NUM-1:0] bitmap_q, bitmap_n;
  logic [PW-1:0]    rr_q, rr_n;
  logic [PW-1:0]    mrr_q, mrr_n;

  logic [NUM_PORTS-1:0]           hold_vld_q, hold_vld_n;
  logic [NUM_PORTS-1:0][ID_W-1:0] hold_id_q, hold_id_n;

  logic [NUM_PORTS-1:0] gnt_q, gnt_n;
  logic [NUM_PORTS-1:0] ready_q, ready_n;
  logic [ID_W-1:0]      alloc_id_q, alloc_id_n;
  logic                 err_q, err_n;
  logic                 done_q, done_n;

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr, mem_wdata;
  logic             pop, push;
  logic             a_found, m_found;
  logic [PW-1:0]    a_port, m_port;
  logic [PTR_W-1:0] pop_id;
  logic [ID_W-1:0]  m_id;

  // First set bit of req searching upward from last+1, wrapping.
  function automatic logic rr_pick(input  logic [NUM_PORTS-1:0] req,
                                   input  logic [PW-1:0]        last,
                                   output logic [PW-1:0]        pick);
    logic          found;
    logic [PW-1:0] idx;
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PW'((int'(last) + i) % NUM_PORTS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return found;
  endfunction

  always_comb begin
    state_n    = state_q;
    init_cnt_n = init_cnt_q;
    rd_ptr_n   = rd_ptr_q;
    wr_ptr_n   = wr_ptr_q;
    count_n    = count_q;
    bitmap_n   = bitmap_q;
    rr_n       = rr_q;
    mrr_n      = mrr_q;
    hold_vld_n = hold_vld_q;
    hold_id_n  = hold_id_q;
    gnt_n      = '0;
    alloc_id_n = '0;
    err_n      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    mem_wdata  = wr_ptr_q;
    pop        = 1'b0;
    push       = 1'b0;
    pop_id     = fl_mem[rd_ptr_q];

    // The port granted last cycle sits out one cycle so it can drop its request.
    a_found = rr_pick(bus.in_alloc_req & ~gnt_q, rr_q, a_port);
    m_found = rr_pick(hold_vld_q, mrr_q, m_port);
    m_id    = hold_id_q[m_port];

    case (state_q)
      INIT_S: begin
        mem_we     = 1'b1;
        wr_ptr_n   = wr_ptr_q + PTR_W'(1);
        count_n    = count_q + CNT_W'(1);
        init_cnt_n = init_cnt_q - PTR_W'(1);
        if (init_cnt_q == '0) begin
          state_n = RUN_S;
        end
      end
      RUN_S: begin
        if (a_found && count_q != '0) begin
          pop               = 1'b1;
          gnt_n[a_port]     = 1'b1;
          alloc_id_n        = ID_W'(pop_id);
          bitmap_n[pop_id]  = 1'b1;
          rr_n              = a_port;
          rd_ptr_n          = rd_ptr_q + PTR_W'(1);
        end
        if (m_found) begin
          hold_vld_n[m_port] = 1'b0;
          mrr_n              = m_port;
          if (m_id[ID_W-1:PTR_W] == '0 && bitmap_q[m_id[PTR_W-1:0]]) begin
            push                        = 1'b1;
            bitmap_n[m_id[PTR_W-1:0]]   = 1'b0;
            mem_we                      = 1'b1;
            mem_wdata                   = m_id[PTR_W-1:0];
            wr_ptr_n                    = wr_ptr_q + PTR_W'(1);
          end else begin
            err_n = 1'b1;
          end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (bus.in_rel_wr[p] && !hold_vld_q[p]) begin
            hold_vld_n[p] = 1'b1;
            hold_id_n[p]  = bus.in_rel_id[p*ID_W +: ID_W];
          end
        end
        count_n = count_q + CNT_W'(push) - CNT_W'(pop);
      end
      default: state_n = INIT_S;
    endcase

    done_n  = (state_n == RUN_S);
    ready_n = done_n ? ~hold_vld_n : '0;
  end

  // Round-robin pointers reset to the last port so port 0 is served first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT_S;
      init_cnt_q <= PTR_W'(ID_NUM - 1);
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      bitmap_q   <= '0;
      rr_q       <= PW'(NUM_PORTS - 1);
      mrr_q      <= PW'(NUM_PORTS - 1);
      hold_vld_q <= '0;
      hold_id_q  <= '0;
      gnt_q      <= '0;
      ready_q    <= '0;
      alloc_id_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      init_cnt_q <= init_cnt_n;
      rd_ptr_q   <= rd_ptr_n;
      wr_ptr_q   <= wr_ptr_n;
      count_q    <= count_n;
      bitmap_q   <= bitmap_n;
      rr_q       <= rr_n;
      mrr_q      <= mrr_n;
      hold_vld_q <= hold_vld_n;
      hold_id_q  <= hold_id_n;
      gnt_q      <= gnt_n;
      ready_q    <= ready_n;
      alloc_id_q <= alloc_id_n;
      err_q      <= err_n;
      done_q     <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      fl_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.out_alloc_gnt  = gnt_q;
  assign bus.out_alloc_id   = alloc_id_q;
  assign bus.out_rel_ready  = ready_q;
  assign bus.out_free_count = count_q;
  assign bus.out_init_done  = done_q;
  assign bus.out_rel_err    = err_q;
endmodule

// File: tb/tb_buf_id_sched.sv
// Self-checking bench for buf_id_sched: directed scenarios plus randomized traffic
// compared against a queue-based free-pool model.
module tb_buf_id_sched;
  localparam int NP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  buf_id_sched_if #(.NUM_PORTS(NP), .ID_W(8)) bus ();
  buf_id_sched #(.NUM_PORTS(NP), .ID_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: pool as a FIFO of free IDs, in-use flags, holding slots.
  int         m_free[$];
  bit         m_used[32];
  bit         m_run;
  int         m_init_left;
  int         m_rr, m_mrr;
  logic [3:0] m_last;
  bit         m_hv[4];
  int         m_hid[4];
  logic [3:0] e_gnt   = '0;
  logic [3:0] e_ready = '0;
  logic [7:0] e_id    = '0;
  int         e_count = 0;
  bit         e_done  = 0;
  bit         e_err   = 0;

  task automatic model_step();
    bit hv_old[4];
    bit found, do_push;
    int p, gp, push_id, id;
    logic [3:0] elig;
    e_err = 0; e_gnt = '0; e_id = '0;
    if (!rst_n) begin
      m_free.delete();
      foreach (m_used[i]) m_used[i] = 0;
      foreach (m_hv[i]) m_hv[i] = 0;
      m_run = 0; m_init_left = 32; m_rr = NP - 1; m_mrr = NP - 1; m_last = '0;
      e_ready = '0; e_done = 0; e_count = 0;
    end else if (!m_run) begin
      m_free.push_back(32 - m_init_left);
      m_init_left--;
      if (m_init_left == 0) m_run = 1;
      e_done = m_run; e_ready = m_run ? 4'hF : 4'h0; e_count = m_free.size();
    end else begin
      hv_old = m_hv;
      do_push = 0; push_id = 0; found = 0; gp = 0;
      for (int k = 1; k <= NP; k++) begin
        p = (m_mrr + k) % NP;
        if (!found && hv_old[p]) begin found = 1; gp = p; end
      end
      if (found) begin
        m_mrr = gp; m_hv[gp] = 0; id = m_hid[gp];
        if (id < 32 && m_used[id]) begin m_used[id] = 0; do_push = 1; push_id = id; end
        else e_err = 1;
      end
      elig = bus.in_alloc_req & ~m_last;
      if (m_free.size() > 0) begin
        found = 0;
        for (int k = 1; k <= NP; k++) begin
          p = (m_rr + k) % NP;
          if (!found && elig[p]) begin found = 1; gp = p; end
        end
        if (found) begin
          id = m_free.pop_front();
          m_used[id] = 1; m_rr = gp; e_gnt[gp] = 1'b1; e_id = 8'(id);
        end
      end
      m_last = e_gnt;
      if (do_push) m_free.push_back(push_id);
      for (int q = 0; q < NP; q++) begin
        if (bus.in_rel_wr[q] && !hv_old[q]) begin m_hv[q] = 1; m_hid[q] = int'(bus.in_rel_id[q*8 +: 8]); end
        e_ready[q] = !m_hv[q];
      end
      e_done = 1; e_count = m_free.size();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_alloc_req = 4'hF; bus.in_rel_wr = '0; bus.in_rel_id = '0;
    tick(); tick();
    checks++;
    if (bus.out_alloc_gnt !== 4'h0 || bus.out_alloc_id !== 8'h0 || bus.out_rel_ready !== 4'h0 ||
        bus.out_free_count !== 6'd0 || bus.out_init_done !== 1'b0 || bus.out_rel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: gnt=%h id=%h rdy=%h cnt=%0d done=%b err=%b, required all zero",
               bus.out_alloc_gnt, bus.out_alloc_id, bus.out_rel_ready, bus.out_free_count,
               bus.out_init_done, bus.out_rel_err);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (bus.out_free_count !== 6'(k) || bus.out_alloc_gnt !== 4'h0 || bus.out_init_done !== 1'(k == 32)) begin
        errors++;
        $display("FAIL init_ramp k=%0d: cnt=%0d gnt=%h done=%b, required cnt=%0d gnt=0 done=%b",
                 k, bus.out_free_count, bus.out_alloc_gnt, bus.out_init_done, k, k == 32);
      end
    end
    bus.in_alloc_req = 4'h0;
    checks++;
    if (bus.out_rel_ready !== 4'hF) begin
      errors++; $display("FAIL init_ready: got %h required f", bus.out_rel_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] prev, exp_g;
    prev = '0;
    bus.in_alloc_req = 4'hF;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_g = 4'b0001 << (i % 4);
      checks++;
      if (bus.out_alloc_gnt !== exp_g || bus.out_alloc_id !== 8'(i) || bus.out_free_count !== 6'(31 - i)) begin
        errors++;
        $display("FAIL rr_grant i=%0d: gnt=%h id=%0d cnt=%0d, required gnt=%h id=%0d cnt=%0d",
                 i, bus.out_alloc_gnt, bus.out_alloc_id, bus.out_free_count, exp_g, i, 31 - i);
      end
      checks++;
      if ((bus.out_alloc_gnt & prev) !== 4'h0) begin
        errors++; $display("FAIL rr_consecutive i=%0d: gnt=%h prev=%h, required no overlap", i, bus.out_alloc_gnt, prev);
      end
      prev = bus.out_alloc_gnt;
    end
  endtask

  task automatic test_exhaust();
    int n;
    n = 0;
    while (bus.out_free_count !== 6'd0 && n < 40) begin
      tick(); n++;
      checks++;
      if (bus.out_alloc_gnt !== e_gnt || bus.out_alloc_id !== e_id || bus.out_free_count !== 6'(e_count)) begin
        errors++;
        $display("FAIL exhaust_grant n=%0d: gnt=%h id=%0d cnt=%0d, required gnt=%h id=%0d cnt=%0d",
                 n, bus.out_alloc_gnt, bus.out_alloc_id, bus.out_free_count, e_gnt, e_id, e_count);
      end
    end
    checks++;
    if (bus.out_free_count !== 6'd0) begin
      errors++; $display("FAIL exhaust_timeout: cnt=%0d required 0 within 40 cycles", bus.out_free_count);
    end
    tick();
    checks++;
    if (bus.out_alloc_gnt !== 4'h0 || bus.out_free_count !== 6'd0) begin
      errors++; $display("FAIL exhaust_no_gnt: gnt=%h cnt=%0d, required gnt=0 cnt=0", bus.out_alloc_gnt, bus.out_free_count);
    end
    bus.in_rel_id = '0; bus.in_rel_id[23:16] = 8'd7; bus.in_rel_wr = 4'b0100;
    tick();
    bus.in_rel_wr = '0;
    checks++;
    if (bus.out_rel_ready !== 4'b1011 || bus.out_alloc_gnt !== 4'h0 || bus.out_free_count !== 6'd0) begin
      errors++; $display("FAIL exhaust_hold: rdy=%h gnt=%h cnt=%0d, required rdy=b gnt=0 cnt=0",
                         bus.out_rel_ready, bus.out_alloc_gnt, bus.out_free_count);
    end
    tick();
    checks++;
    if (bus.out_free_count !== 6'd1 || bus.out_alloc_gnt !== 4'h0 || bus.out_rel_ready !== 4'hF) begin
      errors++; $display("FAIL exhaust_push: cnt=%0d gnt=%h rdy=%h, required cnt=1 gnt=0 rdy=f",
                         bus.out_free_count, bus.out_alloc_gnt, bus.out_rel_ready);
    end
    tick();
    checks++;
    if (bus.out_alloc_gnt === 4'h0 || bus.out_alloc_gnt !== e_gnt || bus.out_alloc_id !== 8'd7 || bus.out_free_count !== 6'd0) begin
      errors++; $display("FAIL exhaust_regrant: gnt=%h id=%0d cnt=%0d, required gnt=%h id=7 cnt=0",
                         bus.out_alloc_gnt, bus.out_alloc_id, bus.out_free_count, e_gnt);
    end
    bus.in_alloc_req = 4'h0;
    tick();
  endtask

  task automatic test_simul_release();
    bus.in_rel_id = {8'd30, 8'd17, 8'd9, 8'd3}; bus.in_rel_wr = 4'hF;
    tick();
    bus.in_rel_wr = '0;
    checks++;
    if (bus.out_rel_ready !== 4'h0 || bus.out_free_count !== 6'd0) begin
      errors++; $display("FAIL simul_hold: rdy=%h cnt=%0d, required rdy=0 cnt=0", bus.out_rel_ready, bus.out_free_count);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (bus.out_free_count !== 6'(k) || bus.out_rel_ready !== e_ready || $countones(bus.out_rel_ready) != k || bus.out_rel_err !== 1'b0) begin
        errors++; $display("FAIL simul_drain k=%0d: cnt=%0d rdy=%h err=%b, required cnt=%0d rdy=%h err=0",
                           k, bus.out_free_count, bus.out_rel_ready, bus.out_rel_err, k, e_ready);
      end
    end
  endtask

  task automatic test_bad_release();
    int errs;
    errs = 0;
    bus.in_rel_id = {8'h25, 8'd12, 8'd12, 8'd3}; bus.in_rel_wr = 4'hF;
    tick();
    bus.in_rel_wr = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.out_rel_err === 1'b1) errs++;
      checks++;
      if (bus.out_rel_err !== e_err || bus.out_rel_ready !== e_ready) begin
        errors++; $display("FAIL bad_pulse k=%0d: err=%b rdy=%h, required err=%b rdy=%h",
                           k, bus.out_rel_err, bus.out_rel_ready, e_err, e_ready);
      end
    end
    checks++;
    if (errs != 3 || bus.out_free_count !== 6'd5) begin
      errors++; $display("FAIL bad_count: err pulses=%0d cnt=%0d, required pulses=3 cnt=5", errs, bus.out_free_count);
    end
    bus.in_rel_id = '0; bus.in_rel_id[7:0] = 8'd5; bus.in_rel_wr = 4'b0001;
    tick();
    bus.in_rel_wr = '0;
    tick();
    checks++;
    if (bus.out_rel_err !== 1'b0 || bus.out_free_count !== 6'd6) begin
      errors++; $display("FAIL bad_bitmap_intact: err=%b cnt=%0d, required err=0 cnt=6", bus.out_rel_err, bus.out_free_count);
    end
  endtask

  task automatic test_random();
    logic [3:0]  wr;
    logic [31:0] ids;
    for (int c = 0; c < 300; c++) begin
      wr = '0; ids = '0;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          wr[p] = 1'b1;
          ids[p*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
        end
      end
      bus.in_alloc_req = 4'($urandom_range(0, 15));
      bus.in_rel_wr = wr; bus.in_rel_id = ids;
      tick();
      checks++;
      if (bus.out_alloc_gnt !== e_gnt || (e_gnt != 4'h0 && bus.out_alloc_id !== e_id) ||
          bus.out_free_count !== 6'(e_count) || bus.out_rel_ready !== e_ready ||
          bus.out_rel_err !== e_err || bus.out_init_done !== e_done) begin
        errors++;
        $display("FAIL random c=%0d: gnt=%h id=%0d cnt=%0d rdy=%h err=%b done=%b, required gnt=%h id=%0d cnt=%0d rdy=%h err=%b done=%b",
                 c, bus.out_alloc_gnt, bus.out_alloc_id, bus.out_free_count, bus.out_rel_ready, bus.out_rel_err,
                 bus.out_init_done, e_gnt, e_id, e_count, e_ready, e_err, e_done);
      end
    end
    bus.in_alloc_req = '0; bus.in_rel_wr = '0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    int g, n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) tick();
    bus.in_alloc_req = 4'hF;
    g = 0; n = 0;
    while (g < 10 && n < 30) begin
      tick(); n++;
      if (bus.out_alloc_gnt !== 4'h0) g++;
    end
    bus.in_alloc_req = 4'h0;
    checks++;
    if (g != 10 || bus.out_free_count !== 6'd22) begin
      errors++; $display("FAIL mid_alloc: grants=%0d cnt=%0d, required grants=10 cnt=22", g, bus.out_free_count);
    end
    bus.in_rel_id = {8'd0, 8'd0, 8'd1, 8'd0}; bus.in_rel_wr = 4'b0011;
    tick();
    bus.in_rel_wr = '0;
    checks++;
    if (bus.out_rel_ready !== 4'b1100) begin
      errors++; $display("FAIL mid_hold: rdy=%h required c", bus.out_rel_ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.out_alloc_gnt !== 4'h0 || bus.out_alloc_id !== 8'h0 || bus.out_rel_ready !== 4'h0 ||
        bus.out_free_count !== 6'd0 || bus.out_init_done !== 1'b0 || bus.out_rel_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_vals: gnt=%h id=%h rdy=%h cnt=%0d done=%b err=%b, required all zero",
               bus.out_alloc_gnt, bus.out_alloc_id, bus.out_rel_ready, bus.out_free_count,
               bus.out_init_done, bus.out_rel_err);
    end
    for (int k = 0; k < 32; k++) tick();
    checks++;
    if (bus.out_free_count !== 6'd32 || bus.out_init_done !== 1'b1 || bus.out_rel_ready !== 4'hF ||
        bus.out_alloc_gnt !== 4'h0 || bus.out_rel_err !== 1'b0) begin
      errors++; $display("FAIL mid_reinit: cnt=%0d done=%b rdy=%h gnt=%h err=%b, required cnt=32 done=1 rdy=f gnt=0 err=0",
                         bus.out_free_count, bus.out_init_done, bus.out_rel_ready, bus.out_alloc_gnt, bus.out_rel_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_alloc_req = '0;
    bus.in_rel_wr    = '0;
    bus.in_rel_id    = '0;
    test_reset();
    test_round_robin();
    test_exhaust();
    test_simul_release();
    test_bad_release();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
